sequenciador_disparo_uc: RTL
============================

// Module: sequenciador_disparo_uc
// PURPOSE
//   Control unit for the turret firing/reload cycle. Accepts fire requests, holds the trigger output for a fixed time,
//   decrements the magazine count, then drives the reload stage (contar high until fim_recarga) and waits for it.
//   Sits directly upstream of servo_recarga_fd: contar_recarga -> contar, fim_recarga <- fim_recarga.
// PARAMETERS
//   MUNICAO_MAX  6          rounds in a full magazine; municao reset/refill value (>=1)
//   W_MUN        3          width of municao; 2**W_MUN > MUNICAO_MAX
//   T_GATILHO    2_000_000  clock cycles gatilho stays high per shot (40 ms @ 50 MHz)
//   W_T          25         width of trigger timer; 2**W_T >= T_GATILHO
// PORTS
//   clock           in   1      system clock, all state on rising edge
//   reset           in   1      asynchronous, active-high; returns block to INICIAL
//   disparar        in   1      fire request level; only the rising edge counts
//   carregar_pente  in   1      magazine refill request (level, sampled per cycle)
//   fim_recarga     in   1      one-cycle pulse from reload stage: reload time elapsed
//   contar_recarga  out  1      enables reload stage counter/servo; high only in RECARGA
//   gatilho         out  1      trigger servo command; high only in DISPARA
//   pronto          out  1      high in PRONTO: a new rising edge on disparar will be accepted
//   sem_municao     out  1      high in VAZIO
//   municao         out  W_MUN  rounds remaining
//   db_estado       out  4      current state encoding, debug
// BEHAVIOUR
//   Reset (async): state=INICIAL, municao=MUNICAO_MAX, edge register=0, timer=0, all 1-bit outputs 0.
//   Edge detect: disparar_d registered every cycle; borda = disparar & ~disparar_d. Edges outside PRONTO are dropped, never queued.
//   Outputs are Moore (decoded from state register); municao is a register.
//   States / transitions (one per clock):
//     INICIAL    -> PRONTO unconditionally (one cycle after reset release).
//     PRONTO     borda -> DISPARA; else carregar_pente -> REABASTECE; else stay. borda has priority over carregar_pente.
//     DISPARA    gatilho=1; timer counts from 0; at T_GATILHO-1 -> DECREMENTA. gatilho is high exactly T_GATILHO cycles.
//     DECREMENTA municao <= municao-1 (never below 0; guarded) -> RECARGA.
//     RECARGA    contar_recarga=1; on fim_recarga -> (municao==0 ? VAZIO : PRONTO); contar_recarga drops the cycle after
//                the pulse, so the reload stage counter wraps to 0 and is clean for the next shot.
//     VAZIO      sem_municao=1; disparar ignored; carregar_pente -> REABASTECE.
//     REABASTECE municao <= MUNICAO_MAX -> PRONTO (one cycle).
//   Latency: edge sampled at clock k -> gatilho high from k+1. Shot-to-pronto = T_GATILHO + 1 + reload time + 1 cycles.
//   fim_recarga outside RECARGA is ignored. carregar_pente outside PRONTO/VAZIO is ignored (no refill mid-shot).
//   Timer is held at zero (synchronous clear) in every state except DISPARA.
//   Reset mid-shot: gatilho and contar_recarga fall immediately (async); municao returns to MUNICAO_MAX.
//   Unused state encodings -> INICIAL on the next clock.
// STRUCTURE
//   Shared include (torreta_defs.vh): state encodings (INICIAL=0, PRONTO=1, DISPARA=2, DECREMENTA=3, RECARGA=4,
//   VAZIO=5, REABASTECE=6) so db_estado decoding matches the display/debug logic; default MUNICAO_MAX.
//   Sub-module: the trigger timer reuses contador_m (N=W_T, M=T_GATILHO, zera_s = ~(state==DISPARA), conta=1).
//   Everything else (FSM, municao register, edge detect) is local.
// TESTING  (bench: MUNICAO_MAX=3, T_GATILHO=4; fim_recarga driven by a model pulsing 10 cycles after contar_recarga rises)
//   1 reset then idle -> INICIAL 1 cycle, then pronto=1, municao=3, gatilho=contar_recarga=sem_municao=0.
//   2 disparar 0->1 held 20 cycles -> gatilho high exactly 4 cycles, municao 3->2, contar_recarga high until fim pulse,
//     pronto again; holding disparar high fires only once.
//   3 three shots -> municao reaches 0, sem_municao=1 in VAZIO; 4th edge gives no gatilho; carregar_pente -> municao=3, pronto=1.
//   4 disparar edge and carregar_pente in same PRONTO cycle -> shot taken (municao 3->2), refill dropped.
//   5 edge on disparar during RECARGA and stray fim_recarga in PRONTO -> both ignored, no state change.
//   6 reset asserted in 2nd gatilho cycle and again during RECARGA -> outputs 0 at once, municao=3, normal shot afterwards.

Source files
------------

// File: rtl/sequenciador_disparo_uc_pkg.sv
// Shared definitions for the turret firing control unit.
// State codes are fixed so db_estado matches the debug display.
package sequenciador_disparo_uc_pkg;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PRONTO     = 4'd1,
    DISPARA    = 4'd2,
    DECREMENTA = 4'd3,
    RECARGA    = 4'd4,
    VAZIO      = 4'd5,
    REABASTECE = 4'd6
  } estado_t;

  localparam int MUNICAO_MAX_DEF = 6;
  localparam int W_MUN_DEF       = 3;
  localparam int T_GATILHO_DEF   = 2_000_000;
  localparam int W_T_DEF         = 25;

endpackage

// File: rtl/sequenciador_disparo_uc_if.sv
// Control/status bundle between the firing control unit and its
// surroundings (operator inputs, reload stage, status outputs).
interface sequenciador_disparo_uc_if #(
  parameter int W_MUN = 3
);

  logic             disparar;
  logic             carregar_pente;
  logic             fim_recarga;
  logic             contar_recarga;
  logic             gatilho;
  logic             pronto;
  logic             sem_municao;
  logic [W_MUN-1:0] municao;
  logic [3:0]       db_estado;

  modport master (
    output disparar,
    output carregar_pente,
    output fim_recarga,
    input  contar_recarga,
    input  gatilho,
    input  pronto,
    input  sem_municao,
    input  municao,
    input  db_estado
  );

  modport slave (
    input  disparar,
    input  carregar_pente,
    input  fim_recarga,
    output contar_recarga,
    output gatilho,
    output pronto,
    output sem_municao,
    output municao,
    output db_estado
  );

endinterface

// File: rtl/sequenciador_disparo_uc_contador_m.sv
// Modulo-M up counter with synchronous clear; fim flags the last
// count. Used as the trigger hold timer.
module sequenciador_disparo_uc_contador_m #(
  parameter int N = 25,
  parameter int M = 2_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] ULTIMO = N'(M - 1);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera_s) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == ULTIMO) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign fim = (q_q == ULTIMO);

endmodule

// File: rtl/sequenciador_disparo_uc.sv
// Turret firing control unit: fire request -> timed trigger ->
// magazine decrement -> reload handshake; refill when empty.
module sequenciador_disparo_uc
  import sequenciador_disparo_uc_pkg::*;
#(
  parameter int MUNICAO_MAX = MUNICAO_MAX_DEF,
  parameter int W_MUN       = W_MUN_DEF,
  parameter int T_GATILHO   = T_GATILHO_DEF,
  parameter int W_T         = W_T_DEF
) (
  input logic                     clock,
  input logic                     reset,
  sequenciador_disparo_uc_if.slave bus
);

  localparam logic [W_MUN-1:0] CHEIO = W_MUN'(MUNICAO_MAX);

  estado_t          est_q, est_d;
  logic [W_MUN-1:0] mun_q, mun_d;
  logic             disp_q, disp_d;
  logic             borda;
  logic             fim_t;

  assign disp_d = bus.disparar;
  assign borda  = bus.disparar & ~disp_q;

  sequenciador_disparo_uc_contador_m #(
    .N (W_T),
    .M (T_GATILHO)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .zera_s (est_q != DISPARA),
    .conta  (1'b1),
    .fim    (fim_t)
  );

  always_comb begin
    est_d = est_q;
    mun_d = mun_q;
    unique case (est_q)
      INICIAL: est_d = PRONTO;
      PRONTO: begin
        if (borda)                   est_d = DISPARA;
        else if (bus.carregar_pente) est_d = REABASTECE;
      end
      DISPARA: begin
        if (fim_t) est_d = DECREMENTA;
      end
      DECREMENTA: begin
        if (mun_q != '0) mun_d = mun_q - W_MUN'(1);
        est_d = RECARGA;
      end
      RECARGA: begin
        if (bus.fim_recarga)
          est_d = (mun_q == '0) ? VAZIO : PRONTO;
      end
      VAZIO: begin
        if (bus.carregar_pente) est_d = REABASTECE;
      end
      REABASTECE: begin
        mun_d = CHEIO;
        est_d = PRONTO;
      end
      default: est_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est_q  <= INICIAL;
      mun_q  <= CHEIO;
      disp_q <= 1'b0;
    end else begin
      est_q  <= est_d;
      mun_q  <= mun_d;
      disp_q <= disp_d;
    end
  end

  // Moore outputs, so reset clears them without waiting for a clock
  assign bus.gatilho        = (est_q == DISPARA);
  assign bus.contar_recarga = (est_q == RECARGA);
  assign bus.pronto         = (est_q == PRONTO);
  assign bus.sem_municao    = (est_q == VAZIO);
  assign bus.municao        = mun_q;
  assign bus.db_estado      = est_q;

endmodule
